// File: rtl/mdu_pkg.sv
// Shared types and defaults for the multiply/divide sequencer.
// The MADD family codes are only acted on when MDU_MADD_EN is defined.
package mdu_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MADD  = 4'd7,
        MD_MADDU = 4'd8,
        MD_MSUB  = 4'd9,
        MD_MSUBU = 4'd10
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu_calc.sv
// Combinational 64-bit {hi,lo} result for one multiply/divide operation.
// MADD/MADDU/MSUB/MSUBU are decoded only when MDU_MADD_EN is defined.
module mdu_calc
    import mdu_pkg::*;
(
    input  md_op_e      op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] res,
    output logic        is_mul,
    output logic        is_div
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [63:0] acc;
    logic signed [31:0] rs_s;
    logic signed [31:0] rt_s;
    logic        [31:0] quo;
    logic        [31:0] rem;

    always_comb begin
        rs_s   = $signed(rs_val);
        rt_s   = $signed(rt_val);
        prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
        prod_u = {32'd0, rs_val} * {32'd0, rt_val};
        acc    = {hi, lo};
        quo    = 32'd0;
        rem    = 32'd0;
        res    = acc;
        is_mul = 1'b0;
        is_div = 1'b0;
        unique case (op)
            MD_MULT: begin
                res    = prod_s;
                is_mul = 1'b1;
            end
            MD_MULTU: begin
                res    = prod_u;
                is_mul = 1'b1;
            end
            MD_DIV: begin
                is_div = 1'b1;
                // Divide by zero keeps the current HI/LO so the commit is a no-op.
                if (rt_val != 32'd0) begin
                    quo = rs_s / rt_s;
                    rem = rs_s % rt_s;
                    res = {rem, quo};
                end
            end
            MD_DIVU: begin
                is_div = 1'b1;
                if (rt_val != 32'd0) begin
                    quo = rs_val / rt_val;
                    rem = rs_val % rt_val;
                    res = {rem, quo};
                end
            end
`ifdef MDU_MADD_EN
            MD_MADD: begin
                res    = acc + prod_s;
                is_mul = 1'b1;
            end
            MD_MADDU: begin
                res    = acc + prod_u;
                is_mul = 1'b1;
            end
            MD_MSUB: begin
                res    = acc - prod_s;
                is_mul = 1'b1;
            end
            MD_MSUBU: begin
                res    = acc - prod_u;
                is_mul = 1'b1;
            end
`endif
            default: begin
                res = acc;
            end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: latches a result at issue, holds busy for a fixed
// latency, then commits to HI/LO. MDU_MADD_EN enables the MADD/MSUB family.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_d,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    md_op_e             op_e;
    logic [63:0]        calc_res;
    logic               calc_mul;
    logic               calc_div;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [31:0]        pend_hi_q, pend_hi_d;
    logic [31:0]        pend_lo_q, pend_lo_d;

    assign op_e = md_op_e'(md_op);

    mdu_calc u_calc (
        .op     (op_e),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .hi     (hi_q),
        .lo     (lo_q),
        .res    (calc_res),
        .is_mul (calc_mul),
        .is_div (calc_div)
    );

    // Issue protocol: start is taken only in IDLE; the hazard unit never
    // raises start while busy is high, so there is no back-pressure path.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (calc_mul || calc_div) begin
                        pend_hi_d = calc_res[63:32];
                        pend_lo_d = calc_res[31:0];
                        cnt_d     = calc_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        state_d   = ST_BUSY;
                    end else if (op_e == MD_MTHI) begin
                        hi_d = rs_val;
                    end else if (op_e == MD_MTLO) begin
                        lo_d = rs_val;
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    assign busy     = (state_q == ST_BUSY);
    // start is included so the instruction right behind a fresh issue stalls too.
    assign stall_md = md_d & (start | busy);
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: a vector table of ops with hand-computed HI/LO
// and busy lengths, plus sequences for stall, MTHI and mid-operation reset.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        md_d;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    int total;
    int bad;

    mdu_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .md_d     (md_d),
        .busy     (busy),
        .stall_md (stall_md),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_busy;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs[NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One-cycle issue: drive at a negedge, clear at the following negedge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start  = 1'b1;
        md_op  = op;
        rs_val = a;
        rt_val = b;
        @(negedge clk);
        start  = 1'b0;
        md_op  = 4'd0;
        rs_val = 32'd0;
        rt_val = 32'd0;
    endtask

    task automatic preset(input logic [31:0] h, input logic [31:0] l);
        issue(MD_MTHI, h, 32'd0);
        issue(MD_MTLO, l, 32'd0);
    endtask

    initial begin
        int n;
        total  = 0;
        bad    = 0;
        start  = 1'b0;
        md_op  = 4'd0;
        rs_val = 32'd0;
        rt_val = 32'd0;
        md_d   = 1'b0;

        //          op        rs            rt            pre_hi        pre_lo        exp_hi        exp_lo        busy
        vecs[0]  = '{MD_MULT,  32'hFFFFFFFD, 32'h00000005, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFF1, 5};
        vecs[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h0,        32'h0,        32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{MD_DIVU,  32'h00000007, 32'h00000000, 32'h00000011, 32'h00000022, 32'h00000011, 32'h00000022, 10};
        vecs[4]  = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h5,        32'h6,        32'h00000001, 32'hFFFFFFFD, 10};
        vecs[5]  = '{MD_DIVU,  32'd100,      32'd7,        32'h0,        32'h0,        32'd2,        32'd14,       10};
        vecs[6]  = '{MD_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0,        32'h0,        32'h3FFFFFFF, 32'h00000001, 5};
        vecs[7]  = '{MD_MULTU, 32'h00010000, 32'h00010000, 32'hA,        32'hB,        32'h00000001, 32'h00000000, 5};
        vecs[8]  = '{MD_DIV,   32'hFFFFFFF8, 32'h00000003, 32'h0,        32'h0,        32'hFFFFFFFE, 32'hFFFFFFFE, 10};
        vecs[9]  = '{MD_NONE,  32'h12345678, 32'h9,        32'h77,       32'h88,       32'h77,       32'h88,       0};
        vecs[10] = '{4'hF,     32'h12345678, 32'h9,        32'h33,       32'h44,       32'h33,       32'h44,       0};
`ifdef MDU_MADD_EN
        vecs[11] = '{MD_MADD,  32'h1,        32'h1,        32'h0,        32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5};
        vecs[12] = '{MD_MSUB,  32'h2,        32'h3,        32'h0,        32'h5,        32'hFFFFFFFF, 32'hFFFFFFFF, 5};
`else
        vecs[11] = '{MD_MADD,  32'h1,        32'h1,        32'h0,        32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 0};
        vecs[12] = '{MD_MSUB,  32'h2,        32'h3,        32'h0,        32'h5,        32'h00000000, 32'h00000005, 0};
`endif

        // Reset state
        reset = 1'b1;
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_stall", {31'd0, stall_md}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven ops
        for (int i = 0; i < NVEC; i++) begin
            preset(vecs[i].pre_hi, vecs[i].pre_lo);
            chk("preset_hi", hi, vecs[i].pre_hi);
            chk("preset_lo", lo, vecs[i].pre_lo);
            issue(vecs[i].op, vecs[i].rs, vecs[i].rt);
            n = 0;
            while (busy === 1'b1 && n < 40) begin
                n++;
                chk("hold_hi", hi, vecs[i].pre_hi);
                chk("hold_lo", lo, vecs[i].pre_lo);
                @(negedge clk);
            end
            chk($sformatf("busy_len[%0d]", i), n, vecs[i].exp_busy);
            chk($sformatf("hi[%0d]", i), hi, vecs[i].exp_hi);
            chk($sformatf("lo[%0d]", i), lo, vecs[i].exp_lo);
        end

        // Stall across issue cycle and every busy cycle, released after busy drops
        @(negedge clk);
        md_d   = 1'b1;
        #1;
        chk("stall_idle", {31'd0, stall_md}, 32'd0);
        start  = 1'b1;
        md_op  = MD_MULT;
        rs_val = 32'd3;
        rt_val = 32'd4;
        #1;
        chk("stall_issue", {31'd0, stall_md}, 32'd1);
        @(negedge clk);
        start  = 1'b0;
        md_op  = 4'd0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            chk("stall_busy", {31'd0, stall_md}, 32'd1);
            @(negedge clk);
        end
        chk("stall_busy_len", n, 32'd5);
        chk("stall_after", {31'd0, stall_md}, 32'd0);
        chk("stall_mult_lo", lo, 32'd12);
        md_d = 1'b0;

        // No stall when D holds an unrelated instruction while busy
        issue(MD_DIVU, 32'd9, 32'd2);
        chk("nostall_busy", {31'd0, busy}, 32'd1);
        chk("nostall_md0", {31'd0, stall_md}, 32'd0);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("divu9_2_lo", lo, 32'd4);
        chk("divu9_2_hi", hi, 32'd1);

        // MTHI visible the next cycle, busy never asserts
        issue(MD_MTHI, 32'h1234, 32'd0);
        chk("mthi_hi", hi, 32'h1234);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("mthi_busy2", {31'd0, busy}, 32'd0);

        // Reset during the 3rd busy cycle of a multiply
        preset(32'hCAFE, 32'hBEEF);
        issue(MD_MULT, 32'd6, 32'd7);
        chk("mid_busy1", {31'd0, busy}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("mid_busy3", {31'd0, busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_hi", hi, 32'd0);
        chk("mid_rst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("post_rst_busy", {31'd0, busy}, 32'd0);
            chk("post_rst_lo", lo, 32'd0);
        end
        chk("post_rst_hi", hi, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
